// File: rtl/ntable_pkg.sv
// Shared definitions for the name-table write path: register select codes
// and the address increment constants selected by the CTRL register.
package ntable_pkg;

    typedef enum logic [1:0] {
        SEL_CTRL      = 2'd0,
        SEL_ADDR      = 2'd1,
        SEL_DATA      = 2'd2,
        SEL_LATCH_CLR = 2'd3
    } wr_sel_e;

    // Bit of the CTRL value that selects the 32-byte (one tile row) stride
    localparam int CTRL_INC_BIT = 2;

    localparam int INC_ONE = 1;
    localparam int INC_32  = 32;

endpackage

// File: rtl/ntable_writer_if.sv
// Register write port of the name-table writer: a byte-wide valid/ready
// handshake carrying a register select and a value.
interface ntable_writer_if #(
    parameter int C_MEMW = 8
);
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [C_MEMW-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output wr_en,
        output wr_sel,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_sel,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/ntable_writer_fifo.sv
// Small synchronous FIFO holding pending name-table writes until the raster
// leaves the visible area. Push is ignored when full, pop when empty; a
// simultaneous push and pop keeps the occupancy unchanged.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; reset discards everything still queued
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ntable_writer.sv
// Name-table writer: decodes PPU-style register writes (CTRL, two-byte ADDR
// latch, DATA, LATCH_CLR), queues DATA writes with their address and drains
// them into the name-table RAM one per clock while the raster is blanked.
module ntable_writer
    import ntable_pkg::*;
#(
    parameter int C_MEMW       = 8,
    parameter int C_AW         = 10,
    parameter int C_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    ntable_writer_if.slave    wr,
    input  logic              visible,
    output logic              ntable_we,
    output logic [C_AW-1:0]   ntable_addr,
    output logic [C_MEMW-1:0] ntable_din,
    output logic              busy
);

    localparam int ENTRY_W = C_AW + C_MEMW;

    logic [C_AW-1:0]    addr;
    logic               inc_32;
    logic               toggle;
    logic [C_AW-1:0]    inc_val;
    wr_sel_e            sel;
    logic               transfer;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] pop_entry;

    assign sel        = wr_sel_e'(wr.wr_sel);
    assign wr.wr_ready = !fifo_full;
    assign transfer   = wr.wr_en && !fifo_full;
    assign push       = transfer && (sel == SEL_DATA);
    assign pop        = !visible && !fifo_empty;
    assign busy       = !fifo_empty;
    assign inc_val    = inc_32 ? C_AW'(INC_32) : C_AW'(INC_ONE);
    assign push_entry = {addr, wr.wr_data};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Register decode: increment mode, high/low address latch and the
    // post-DATA auto-increment, all wrapping at the address width
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr   <= '0;
            inc_32 <= 1'b0;
            toggle <= 1'b0;
        end else if (transfer) begin
            case (sel)
                SEL_CTRL: begin
                    inc_32 <= wr.wr_data[CTRL_INC_BIT];
                end
                SEL_ADDR: begin
                    if (!toggle) begin
                        addr[C_AW-1:8] <= wr.wr_data[C_AW-9:0];
                    end else begin
                        addr[7:0] <= wr.wr_data[7:0];
                    end
                    toggle <= !toggle;
                end
                SEL_DATA: begin
                    addr <= addr + inc_val;
                end
                SEL_LATCH_CLR: begin
                    toggle <= 1'b0;
                end
                default: begin
                    toggle <= toggle;
                end
            endcase
        end
    end

    // RAM write port: a popped entry becomes a one-cycle strobe, address and
    // data hold their last values between strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            ntable_we   <= 1'b0;
            ntable_addr <= '0;
            ntable_din  <= '0;
        end else if (pop) begin
            ntable_we   <= 1'b1;
            ntable_addr <= pop_entry[ENTRY_W-1:C_MEMW];
            ntable_din  <= pop_entry[C_MEMW-1:0];
        end else begin
            ntable_we   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ntable_writer.sv
// Self-checking bench for ntable_writer: directed scenarios plus a random
// register-write stream compared against a behavioural model of the
// register semantics and an in-order write list.
module tb_ntable_writer;
    import ntable_pkg::*;

    localparam int C_MEMW       = 8;
    localparam int C_AW         = 10;
    localparam int C_FIFO_DEPTH = 4;

    localparam logic [1:0] S_CTRL = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_CLR  = 2'd3;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        int         cyc;
        logic       vis;
    } cap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       visible = 1'b0;
    logic       ntable_we;
    logic [9:0] ntable_addr;
    logic [7:0] ntable_din;
    logic       busy;

    int         n_checks = 0;
    int         n_fails  = 0;
    int         cyc      = 0;
    bit         rand_vis = 0;

    cap_t        cap_q[$];
    cap_t        cap_tmp;
    logic        cap_vis;
    logic [17:0] exp_q[$];

    int m_addr;
    bit m_inc32;
    bit m_tog;

    ntable_writer_if #(.C_MEMW(C_MEMW)) wr_if ();

    ntable_writer #(
        .C_MEMW       (C_MEMW),
        .C_AW         (C_AW),
        .C_FIFO_DEPTH (C_FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr_if),
        .visible     (visible),
        .ntable_we   (ntable_we),
        .ntable_addr (ntable_addr),
        .ntable_din  (ntable_din),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every RAM strobe together with the visible level its pop edge saw
    always @(posedge clk) begin
        cap_vis = visible;
        #2;
        if (ntable_we === 1'b1) begin
            cap_tmp.addr = ntable_addr;
            cap_tmp.data = ntable_din;
            cap_tmp.cyc  = cyc;
            cap_tmp.vis  = cap_vis;
            cap_q.push_back(cap_tmp);
        end
    end

    function automatic void model_reset();
        m_addr  = 0;
        m_inc32 = 0;
        m_tog   = 0;
    endfunction

    function automatic void model_apply(input logic [1:0] sel, input logic [7:0] d);
        case (sel)
            S_CTRL: m_inc32 = d[2];
            S_ADDR: begin
                if (!m_tog) m_addr = (m_addr % 256) + 256 * (int'(d) % 4);
                else        m_addr = (m_addr / 256) * 256 + int'(d);
                m_tog = !m_tog;
            end
            S_DATA: begin
                exp_q.push_back({10'(m_addr), d});
                m_addr = (m_addr + (m_inc32 ? 32 : 1)) % 1024;
            end
            default: m_tog = 0;
        endcase
    endfunction

    task automatic write_reg(input logic [1:0] sel, input logic [7:0] d, output int acc);
        bit done;
        done = 0;
        acc  = -1;
        wr_if.wr_en   = 1'b1;
        wr_if.wr_sel  = sel;
        wr_if.wr_data = d;
        for (int i = 0; i < 200 && !done; i++) begin
            if (wr_if.wr_ready === 1'b1) begin
                model_apply(sel, d);
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
                if (rand_vis) visible = 1'($urandom_range(0, 1));
            end
        end
        if (done) begin
            @(negedge clk);
            acc = cyc;
        end else begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL write_accept timeout: wr_ready=%b required=1", wr_if.wr_ready);
        end
        wr_if.wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while (cap_q.size() < exp_q.size() && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (cap_q.size() < exp_q.size()) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL %s drain timeout: got %0d strobes required %0d", tag, cap_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        wr_if.wr_en = 1'b0; wr_if.wr_sel = 2'd0; wr_if.wr_data = 8'd0;
        rst = 1'b0;
        visible = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        n_checks += 5;
        if (wr_if.wr_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_ready: got %b required 1", wr_if.wr_ready); end
        if (ntable_we !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_we: got %b required 0", ntable_we); end
        if (ntable_addr !== 10'h000) begin n_fails++; $display("[TB] FAIL reset_addr: got %h required 000", ntable_addr); end
        if (ntable_din !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_din: got %h required 00", ntable_din); end
        if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_basic();
        int cb, acc, dummy;
        cb = cap_q.size();
        visible = 1'b0;
        write_reg(S_ADDR, 8'h01, dummy);
        write_reg(S_ADDR, 8'h23, dummy);
        write_reg(S_DATA, 8'hAA, acc);
        write_reg(S_DATA, 8'hBB, dummy);
        wait_drain("basic");
        n_checks++;
        if (cap_q.size() - cb !== 2) begin
            n_fails++; $display("[TB] FAIL basic_count: got %0d required 2", cap_q.size() - cb);
        end else begin
            n_checks += 6;
            if (cap_q[cb].addr !== 10'h123) begin n_fails++; $display("[TB] FAIL basic_addr0: got %h required 123", cap_q[cb].addr); end
            if (cap_q[cb].data !== 8'hAA) begin n_fails++; $display("[TB] FAIL basic_data0: got %h required aa", cap_q[cb].data); end
            if (cap_q[cb+1].addr !== 10'h124) begin n_fails++; $display("[TB] FAIL basic_addr1: got %h required 124", cap_q[cb+1].addr); end
            if (cap_q[cb+1].data !== 8'hBB) begin n_fails++; $display("[TB] FAIL basic_data1: got %h required bb", cap_q[cb+1].data); end
            if (cap_q[cb].cyc !== acc + 1) begin n_fails++; $display("[TB] FAIL basic_latency: got cycle %0d required %0d", cap_q[cb].cyc, acc + 1); end
            if (cap_q[cb+1].cyc !== cap_q[cb].cyc + 1) begin n_fails++; $display("[TB] FAIL basic_back_to_back: got cycle %0d required %0d", cap_q[cb+1].cyc, cap_q[cb].cyc + 1); end
        end
    endtask

    task automatic test_wrap();
        int cb, dummy;
        logic [9:0] want_a [4];
        logic [7:0] want_d [4];
        want_a[0] = 10'h3F0; want_d[0] = 8'h11;
        want_a[1] = 10'h010; want_d[1] = 8'h22;
        want_a[2] = 10'h3FF; want_d[2] = 8'h33;
        want_a[3] = 10'h000; want_d[3] = 8'h44;
        cb = cap_q.size();
        visible = 1'b0;
        write_reg(S_CTRL, 8'h04, dummy);
        write_reg(S_ADDR, 8'h03, dummy);
        write_reg(S_ADDR, 8'hF0, dummy);
        write_reg(S_DATA, 8'h11, dummy);
        write_reg(S_DATA, 8'h22, dummy);
        write_reg(S_CTRL, 8'h00, dummy);
        write_reg(S_ADDR, 8'h03, dummy);
        write_reg(S_ADDR, 8'hFF, dummy);
        write_reg(S_DATA, 8'h33, dummy);
        write_reg(S_DATA, 8'h44, dummy);
        wait_drain("wrap");
        n_checks++;
        if (cap_q.size() - cb !== 4) begin
            n_fails++; $display("[TB] FAIL wrap_count: got %0d required 4", cap_q.size() - cb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (cap_q[cb+i].addr !== want_a[i] || cap_q[cb+i].data !== want_d[i]) begin
                    n_fails++;
                    $display("[TB] FAIL wrap_write%0d: got %h/%h required %h/%h", i, cap_q[cb+i].addr, cap_q[cb+i].data, want_a[i], want_d[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        int cb, eb, dummy;
        cb = cap_q.size();
        eb = exp_q.size();
        visible = 1'b1;
        for (int i = 0; i < 4; i++) write_reg(S_DATA, 8'($urandom), dummy);
        wr_if.wr_en = 1'b1; wr_if.wr_sel = S_DATA; wr_if.wr_data = 8'h99;
        n_checks += 2;
        if (wr_if.wr_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL full_ready: got %b required 0", wr_if.wr_ready); end
        if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL full_busy: got %b required 1", busy); end
        @(posedge clk);
        @(negedge clk);
        n_checks += 2;
        if (wr_if.wr_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL full_ready_held: got %b required 0", wr_if.wr_ready); end
        if (cap_q.size() !== cb || ntable_we !== 1'b0) begin n_fails++; $display("[TB] FAIL full_no_strobe: got %0d strobes we=%b required 0", cap_q.size() - cb, ntable_we); end
        wr_if.wr_en = 1'b0;
        visible = 1'b0;
        wait_drain("full");
        n_checks += 2;
        if (cap_q.size() - cb !== 4) begin
            n_fails++; $display("[TB] FAIL full_count: got %0d required 4", cap_q.size() - cb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks += 2;
                if ({cap_q[cb+i].addr, cap_q[cb+i].data} !== exp_q[eb+i]) begin
                    n_fails++; $display("[TB] FAIL full_order%0d: got %h/%h required %h", i, cap_q[cb+i].addr, cap_q[cb+i].data, exp_q[eb+i]);
                end
                if (cap_q[cb+i].cyc !== cap_q[cb].cyc + i) begin
                    n_fails++; $display("[TB] FAIL full_consecutive%0d: got cycle %0d required %0d", i, cap_q[cb+i].cyc, cap_q[cb].cyc + i);
                end
            end
        end
        if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL full_busy_fall: got %b required 0", busy); end
        write_reg(S_DATA, 8'h99, dummy);
        wait_drain("full_fifth");
        if (cap_q.size() - cb !== 5 || {cap_q[cb+4].addr, cap_q[cb+4].data} !== exp_q[eb+4]) begin
            n_fails++; $display("[TB] FAIL full_fifth: got %0d strobes last %h/%h required %h", cap_q.size() - cb, cap_q[cap_q.size()-1].addr, cap_q[cap_q.size()-1].data, exp_q[eb+4]);
        end
    endtask

    task automatic test_latch_clr();
        int cb, dummy;
        cb = cap_q.size();
        visible = 1'b0;
        write_reg(S_ADDR, 8'h02, dummy);
        write_reg(S_CLR,  8'h00, dummy);
        write_reg(S_ADDR, 8'h01, dummy);
        write_reg(S_ADDR, 8'h00, dummy);
        write_reg(S_DATA, 8'h5A, dummy);
        wait_drain("latch_clr");
        n_checks++;
        if (cap_q.size() - cb !== 1 || cap_q[cb].addr !== 10'h100 || cap_q[cb].data !== 8'h5A) begin
            n_fails++; $display("[TB] FAIL latch_clr_write: got %0d strobes %h/%h required 1 at 100/5a", cap_q.size() - cb, cap_q[cb].addr, cap_q[cb].data);
        end
    endtask

    task automatic test_reset_flush();
        int cb, eb, dummy;
        cb = cap_q.size();
        eb = exp_q.size();
        visible = 1'b1;
        for (int i = 0; i < 3; i++) write_reg(S_DATA, 8'($urandom), dummy);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        while (exp_q.size() > eb) void'(exp_q.pop_back());
        n_checks += 5;
        if (wr_if.wr_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL flush_ready: got %b required 1", wr_if.wr_ready); end
        if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL flush_busy: got %b required 0", busy); end
        if (ntable_we !== 1'b0) begin n_fails++; $display("[TB] FAIL flush_we: got %b required 0", ntable_we); end
        if (ntable_addr !== 10'h000) begin n_fails++; $display("[TB] FAIL flush_addr: got %h required 000", ntable_addr); end
        if (ntable_din !== 8'h00) begin n_fails++; $display("[TB] FAIL flush_din: got %h required 00", ntable_din); end
        visible = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (cap_q.size() !== cb) begin n_fails++; $display("[TB] FAIL flush_no_strobe: got %0d strobes required 0", cap_q.size() - cb); end
        write_reg(S_DATA, 8'h77, dummy);
        wait_drain("flush");
        n_checks++;
        if (cap_q.size() - cb !== 1 || cap_q[cb].addr !== 10'h000 || cap_q[cb].data !== 8'h77) begin
            n_fails++; $display("[TB] FAIL flush_next_write: got %0d strobes %h/%h required 1 at 000/77", cap_q.size() - cb, cap_q[cb].addr, cap_q[cb].data);
        end
    endtask

    task automatic test_simul_push_pop();
        int cb, eb, dummy;
        cb = cap_q.size();
        eb = exp_q.size();
        visible = 1'b1;
        write_reg(S_DATA, 8'hA1, dummy);
        write_reg(S_DATA, 8'hA2, dummy);
        visible = 1'b0;
        write_reg(S_DATA, 8'hA3, dummy);
        visible = 1'b1;
        n_checks++;
        if (cap_q.size() - cb !== 1) begin n_fails++; $display("[TB] FAIL simul_one_pop: got %0d strobes required 1", cap_q.size() - cb); end
        write_reg(S_DATA, 8'hA4, dummy);
        write_reg(S_DATA, 8'hA5, dummy);
        wr_if.wr_en = 1'b1; wr_if.wr_sel = S_DATA; wr_if.wr_data = 8'hA6;
        n_checks++;
        if (wr_if.wr_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL simul_count: got wr_ready=%b required 0", wr_if.wr_ready); end
        wr_if.wr_en = 1'b0;
        visible = 1'b0;
        wait_drain("simul");
        n_checks++;
        if (cap_q.size() - cb !== 5) begin
            n_fails++; $display("[TB] FAIL simul_total: got %0d required 5", cap_q.size() - cb);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if ({cap_q[cb+i].addr, cap_q[cb+i].data} !== exp_q[eb+i]) begin
                    n_fails++; $display("[TB] FAIL simul_order%0d: got %h/%h required %h", i, cap_q[cb+i].addr, cap_q[cb+i].data, exp_q[eb+i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int cb, eb, dummy, r, bad_vis;
        logic [1:0] sel;
        cb = cap_q.size();
        eb = exp_q.size();
        rand_vis = 1;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      sel = S_DATA;
            else if (r < 7) sel = S_ADDR;
            else if (r < 9) sel = S_CTRL;
            else            sel = S_CLR;
            visible = 1'($urandom_range(0, 1));
            write_reg(sel, 8'($urandom), dummy);
        end
        rand_vis = 0;
        visible = 1'b0;
        wait_drain("random");
        n_checks++;
        if (cap_q.size() - cb !== exp_q.size() - eb) begin
            n_fails++; $display("[TB] FAIL random_count: got %0d required %0d", cap_q.size() - cb, exp_q.size() - eb);
        end else begin
            for (int i = 0; i < exp_q.size() - eb; i++) begin
                n_checks++;
                if ({cap_q[cb+i].addr, cap_q[cb+i].data} !== exp_q[eb+i]) begin
                    n_fails++; $display("[TB] FAIL random_write%0d: got %h/%h required %h", i, cap_q[cb+i].addr, cap_q[cb+i].data, exp_q[eb+i]);
                end
            end
        end
        bad_vis = 0;
        for (int i = 0; i < cap_q.size(); i++) if (cap_q[i].vis !== 1'b0) bad_vis++;
        n_checks += 2;
        if (bad_vis != 0) begin n_fails++; $display("[TB] FAIL strobe_during_visible: got %0d required 0", bad_vis); end
        if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL random_busy_end: got %b required 0", busy); end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] ntable_writer bench start");
        wr_if.wr_en = 1'b0;
        wr_if.wr_sel = 2'd0;
        wr_if.wr_data = 8'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_latch_clr();
        test_reset_flush();
        test_simul_push_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
